// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order req/gnt/rvalid fetches and buffers
// returned words so the IF/ID stage sees one registered {inst_addr, inst} per cycle.

module ifu_fetch_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] out_cnt,
    input  logic             rvalid
);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, cnt} <= DEPTH_C);
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, cnt} + {1'b0, out_cnt}) <= DEPTH_C);
    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        rvalid |-> (out_cnt != {CNT_W{1'b0}}));
endmodule

module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RST_ADDR   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  hold_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [INST_WIDTH-1:0] imem_rdata_i,
    output logic                  inst_valid_o,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic [INST_WIDTH-1:0] inst_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [INST_WIDTH-1:0] INST_NOP = INST_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(3'd4);
    localparam logic [CNT_W:0]        DEPTH_W  = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ZERO = {PTR_W{1'b0}};

    logic [ADDR_WIDTH-1:0] pc_r, pc_nxt;
    logic [CNT_W-1:0]      out_cnt_r, out_cnt_nxt;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt, cnt_after_pop_s;
    logic [CNT_W-1:0]      drop_r, drop_nxt;
    logic [PTR_W-1:0]      aq_wr_r, aq_rd_r, aq_wr_nxt, aq_rd_nxt;
    logic [PTR_W-1:0]      fq_wr_r, fq_rd_r, fq_wr_nxt, fq_rd_nxt;
    logic [ADDR_WIDTH-1:0] aq_mem_r  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fq_addr_r [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] fq_inst_r [FIFO_DEPTH];
    logic                  valid_r, valid_nxt;
    logic [ADDR_WIDTH-1:0] out_addr_r, out_addr_nxt;
    logic [INST_WIDTH-1:0] out_inst_r, out_inst_nxt;
    logic [CNT_W:0]        used_s;
    logic [ADDR_WIDTH-1:0] aq_head_s;
    logic                  pop_s, req_s, grant_s, push_s;

    // Handshake decode, credit accounting and next-state for counters, pointers and output head
    always_comb begin
        pop_s     = valid_r && !hold_i;
        // Counting this cycle's pop lets a 1-cycle memory sustain one instruction per cycle
        used_s    = {1'b0, out_cnt_r} + {1'b0, cnt_r} - {{CNT_W{1'b0}}, pop_s};
        req_s     = rst_n && !jump_i && (used_s < DEPTH_W);
        grant_s   = req_s && imem_gnt_i;
        push_s    = imem_rvalid_i && (drop_r == CNT_ZERO) && !jump_i;
        aq_head_s = aq_mem_r[aq_rd_r];

        aq_wr_nxt   = aq_wr_r + PTR_W'(grant_s);
        aq_rd_nxt   = aq_rd_r + PTR_W'(imem_rvalid_i);
        out_cnt_nxt = out_cnt_r + CNT_W'(grant_s) - CNT_W'(imem_rvalid_i);
        cnt_after_pop_s = cnt_r - CNT_W'(pop_s);

        if (jump_i) begin
            pc_nxt    = jump_addr_i;
            drop_nxt  = out_cnt_nxt;
            cnt_nxt   = CNT_ZERO;
            fq_wr_nxt = PTR_ZERO;
            fq_rd_nxt = PTR_ZERO;
        end else begin
            pc_nxt    = grant_s ? (pc_r + PC_STEP) : pc_r;
            if (imem_rvalid_i && (drop_r != CNT_ZERO)) begin
                drop_nxt = drop_r - CNT_W'(1'b1);
            end else begin
                drop_nxt = drop_r;
            end
            cnt_nxt   = cnt_after_pop_s + CNT_W'(push_s);
            fq_wr_nxt = fq_wr_r + PTR_W'(push_s);
            fq_rd_nxt = fq_rd_r + PTR_W'(pop_s);
        end

        // The word being pushed becomes the head directly when nothing older remains
        if (jump_i || (cnt_nxt == CNT_ZERO)) begin
            valid_nxt    = 1'b0;
            out_addr_nxt = out_addr_r;
            out_inst_nxt = INST_NOP;
        end else if (cnt_after_pop_s == CNT_ZERO) begin
            valid_nxt    = 1'b1;
            out_addr_nxt = aq_head_s;
            out_inst_nxt = imem_rdata_i;
        end else begin
            valid_nxt    = 1'b1;
            out_addr_nxt = fq_addr_r[fq_rd_nxt];
            out_inst_nxt = fq_inst_r[fq_rd_nxt];
        end
    end

    // Control state and registered output head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RST_ADDR;
            out_cnt_r  <= CNT_ZERO;
            cnt_r      <= CNT_ZERO;
            drop_r     <= CNT_ZERO;
            aq_wr_r    <= PTR_ZERO;
            aq_rd_r    <= PTR_ZERO;
            fq_wr_r    <= PTR_ZERO;
            fq_rd_r    <= PTR_ZERO;
            valid_r    <= 1'b0;
            out_addr_r <= RST_ADDR;
            out_inst_r <= INST_NOP;
        end else begin
            pc_r       <= pc_nxt;
            out_cnt_r  <= out_cnt_nxt;
            cnt_r      <= cnt_nxt;
            drop_r     <= drop_nxt;
            aq_wr_r    <= aq_wr_nxt;
            aq_rd_r    <= aq_rd_nxt;
            fq_wr_r    <= fq_wr_nxt;
            fq_rd_r    <= fq_rd_nxt;
            valid_r    <= valid_nxt;
            out_addr_r <= out_addr_nxt;
            out_inst_r <= out_inst_nxt;
        end
    end

    // Granted-address queue and returned-word buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                aq_mem_r[i]  <= {ADDR_WIDTH{1'b0}};
                fq_addr_r[i] <= {ADDR_WIDTH{1'b0}};
                fq_inst_r[i] <= {INST_WIDTH{1'b0}};
            end
        end else begin
            if (grant_s) begin
                aq_mem_r[aq_wr_r] <= pc_r;
            end
            if (push_s) begin
                fq_addr_r[fq_wr_r] <= aq_head_s;
                fq_inst_r[fq_wr_r] <= imem_rdata_i;
            end
        end
    end

    assign imem_req_o   = req_s;
    assign imem_addr_o  = pc_r;
    assign inst_valid_o = valid_r;
    assign inst_addr_o  = out_addr_r;
    assign inst_o       = out_inst_r;

    ifu_fetch_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt     (cnt_r),
        .out_cnt (out_cnt_r),
        .rvalid  (imem_rvalid_i)
    );
endmodule
